seg_scan_decoder: RTL

Receive-side counterpart of the team's multiplexed 4-digit seven-segment binary display driver. It samples a time-multiplexed anode/segment bus, filters transition glitches, decodes each digit's segment pattern back to a hex value, and assembles complete 4-digit frames. It is used in benches and on-board self-check to recover the value a display driver is showing.

---
 rtl/seg_scan_decoder_if.sv | 28 ++
 rtl/seg_scan_decoder.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_decoder_if : anode/segment scan bus and decoded-frame outputs    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface seg_scan_decoder_if;
  logic [3:0]  i_anodes;
  logic [7:0]  i_segments;
  logic [15:0] o_data;
  logic [3:0]  o_bits;
  logic        o_bin;
  logic [3:0]  o_bad;
  logic [3:0]  o_dp;
  logic        o_valid;
  logic        o_an_err;

  modport master (
    output i_anodes, i_segments,
    input  o_data, o_bits, o_bin, o_bad, o_dp, o_valid, o_an_err
  );

  modport slave (
    input  i_anodes, i_segments,
    output o_data, o_bits, o_bin, o_bad, o_dp, o_valid, o_an_err
  );
endinterface
`default_nettype wire

// File: rtl/seg_scan_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_scan_decoder : recovers 4-digit hex frames from a muxed 7-seg bus     |
// | Optional SEG_SCAN_DP_EN captures decimal points. Rev 1.0                  |
// +--------------------------------------------------------------------------+
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_decoder_if.slave  bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] c_cnt_max  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] c_cnt_cap  = CW'(STABLE_CYCLES - 1);
  localparam logic [11:0]   c_pair_rst = {4'hF, 8'h00};

  logic [11:0]      w_in, r_pair;
  logic [CW-1:0]    r_stab_cnt;
  logic             w_same, w_capture, w_an_multi, w_frame_done;
  logic [3:0]       w_an_low, w_cap_oh, w_seen_nxt, r_seen;
  logic [3:0]       w_dec_hex;
  logic             w_dec_bad;
  logic [3:0][3:0]  r_dig, w_dig_nxt;
  logic [3:0]       r_bad, w_bad_nxt, w_bit, w_bin_ok;
  logic [15:0]      r_data;
  logic [3:0]       r_bits, r_bad_out;
  logic             r_bin, r_valid, r_an_err;

  assign w_in      = {bus.i_anodes, bus.i_segments};
  assign w_same    = (w_in == r_pair);
  // Fires once per stable period because the counter saturates past this value.
  assign w_capture = w_same && (r_stab_cnt == c_cnt_cap);
  assign w_an_low  = ~r_pair[11:8];
  assign w_cap_oh  = (w_capture && $onehot(w_an_low)) ? w_an_low : 4'b0000;
  assign w_an_multi   = w_capture && ($countones(w_an_low) > 1);
  assign w_seen_nxt   = r_seen | w_cap_oh;
  assign w_frame_done = (w_cap_oh != 4'b0000) && (w_seen_nxt == 4'hF);

  always_comb begin
    w_dec_hex = 4'h0;
    w_dec_bad = 1'b0;
    case ({r_pair[7:1], 1'b0})
      8'hFC: w_dec_hex = 4'h0;
      8'h60: w_dec_hex = 4'h1;
      8'hDA: w_dec_hex = 4'h2;
      8'hF2: w_dec_hex = 4'h3;
      8'h66: w_dec_hex = 4'h4;
      8'hB6: w_dec_hex = 4'h5;
      8'hBE: w_dec_hex = 4'h6;
      8'hE0: w_dec_hex = 4'h7;
      8'hFE: w_dec_hex = 4'h8;
      8'hF6: w_dec_hex = 4'h9;
      8'hEE: w_dec_hex = 4'hA;
      8'h3E: w_dec_hex = 4'hB;
      8'h9C: w_dec_hex = 4'hC;
      8'h7A: w_dec_hex = 4'hD;
      8'h9E: w_dec_hex = 4'hE;
      8'h8E: w_dec_hex = 4'hF;
      default: w_dec_bad = 1'b1;
    endcase
  end

  // Next-state view of each digit includes the capture on this edge, so a
  // completing frame reports the digit just captured.
  for (genvar n = 0; n < 4; n++) begin : g_digit
    assign w_dig_nxt[n] = w_cap_oh[n] ? w_dec_hex : r_dig[n];
    assign w_bad_nxt[n] = w_cap_oh[n] ? w_dec_bad : r_bad[n];
    assign w_bit[n]     = (w_dig_nxt[n] == 4'h1);
    assign w_bin_ok[n]  = (w_dig_nxt[n] <= 4'h1) && !w_bad_nxt[n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pair     <= c_pair_rst;
      r_stab_cnt <= '0;
    end else begin
      r_pair <= w_in;
      if (!w_same)
        r_stab_cnt <= '0;
      else if (r_stab_cnt != c_cnt_max)
        r_stab_cnt <= r_stab_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig     <= '0;
      r_bad     <= '0;
      r_seen    <= '0;
      r_data    <= '0;
      r_bits    <= '0;
      r_bin     <= 1'b0;
      r_bad_out <= '0;
      r_valid   <= 1'b0;
      r_an_err  <= 1'b0;
    end else begin
      r_dig    <= w_dig_nxt;
      r_bad    <= w_bad_nxt;
      r_valid  <= w_frame_done;
      r_an_err <= w_an_multi;
      if (w_frame_done) begin
        r_seen    <= 4'b0000;
        r_data    <= w_dig_nxt;
        r_bits    <= w_bit;
        r_bin     <= &w_bin_ok;
        r_bad_out <= w_bad_nxt;
      end else begin
        r_seen <= w_seen_nxt;
      end
    end
  end

`ifdef SEG_SCAN_DP_EN
  logic [3:0] r_dp, w_dp_nxt, r_dp_out;

  for (genvar n = 0; n < 4; n++) begin : g_dp
    assign w_dp_nxt[n] = w_cap_oh[n] ? r_pair[0] : r_dp[n];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp     <= '0;
      r_dp_out <= '0;
    end else begin
      r_dp <= w_dp_nxt;
      if (w_frame_done)
        r_dp_out <= w_dp_nxt;
    end
  end

  assign bus.o_dp = r_dp_out;
`else
  assign bus.o_dp = 4'b0000;
`endif

  assign bus.o_data   = r_data;
  assign bus.o_bits   = r_bits;
  assign bus.o_bin    = r_bin;
  assign bus.o_bad    = r_bad_out;
  assign bus.o_valid  = r_valid;
  assign bus.o_an_err = r_an_err;
endmodule
`default_nettype wire
